// File: rtl/fifo_multi_lane_if.sv
// fifo_multi_lane_if: push/pop lanes, grants and occupancy status of the multi-lane FIFO.
interface fifo_multi_lane_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int LANES = 8
);
  localparam int CW = $clog2(LANES + 1);
  localparam int NW = $clog2(DEPTH + 1);
  logic [CW-1:0]               push_cnt;
  logic [CW-1:0]               push_acc;
  logic [CW-1:0]               pop_cnt;
  logic [CW-1:0]               pop_acc;
  logic [LANES-1:0][WIDTH-1:0] wdata;
  logic [LANES-1:0][WIDTH-1:0] rdata;
  logic                        flush;
  logic [NW-1:0]               count;
  logic [NW-1:0]               free;
  logic                        full;
  logic                        empty;
  logic                        afull;
  modport master (
    output push_cnt, wdata, pop_cnt, flush,
    input  push_acc, rdata, pop_acc, count, free, full, empty, afull
  );
  modport slave (
    input  push_cnt, wdata, pop_cnt, flush,
    output push_acc, rdata, pop_acc, count, free, full, empty, afull
  );
endinterface

// File: rtl/fifo_multi_lane.sv
// fifo_multi_lane: in-order FIFO moving 0..LANES words in and out per cycle with explicit grant counts.
module fifo_multi_lane #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int LANES    = 8,
  parameter int PARTIAL  = 1,
  parameter int FLUSH_EN = 1
) (
  input logic              clk,
  input logic              rst_n,
  fifo_multi_lane_if.slave bus
);
  localparam int CW = $clog2(LANES + 1);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]    count_q, count_d, free_w;
  logic [CW-1:0]    push_req, pop_req, push_acc, pop_acc;
  logic             push_fit, pop_fit, flush_w;
  assign flush_w = (FLUSH_EN != 0) && bus.flush;
  assign free_w  = NW'(DEPTH) - count_q;
  // Grants see only registered occupancy, so a word pushed now is never popped in the same cycle.
  always_comb begin
    push_req = (bus.push_cnt > CW'(LANES)) ? CW'(LANES) : bus.push_cnt;
    pop_req  = (bus.pop_cnt > CW'(LANES)) ? CW'(LANES) : bus.pop_cnt;
    push_fit = NW'(push_req) <= free_w;
    pop_fit  = NW'(pop_req) <= count_q;
    push_acc = flush_w ? '0 : push_fit ? push_req : (PARTIAL != 0) ? CW'(free_w) : '0;
    pop_acc  = flush_w ? '0 : pop_fit ? pop_req : (PARTIAL != 0) ? CW'(count_q) : '0;
    rd_ptr_d = flush_w ? '0 : rd_ptr_q + PW'(pop_acc);
    wr_ptr_d = flush_w ? '0 : wr_ptr_q + PW'(push_acc);
    count_d  = flush_w ? '0 : count_q + NW'(push_acc) - NW'(pop_acc);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (CW'(i) < push_acc) mem_q[wr_ptr_q + PW'(i)] <= bus.wdata[i];
  end
  for (genvar i = 0; i < LANES; i++) begin : g_rd
    assign bus.rdata[i] = (CW'(i) < pop_acc) ? mem_q[rd_ptr_q + PW'(i)] : '0;
  end
  assign bus.push_acc = push_acc;
  assign bus.pop_acc  = pop_acc;
  assign bus.count    = count_q;
  assign bus.free     = free_w;
  assign bus.full     = count_q == NW'(DEPTH);
  assign bus.empty    = count_q == '0;
  assign bus.afull    = free_w < NW'(LANES);
endmodule

// File: tb/tb_fifo_multi_lane.sv
// tb_fifo_multi_lane: vector table over default, all-or-nothing and no-flush FIFO instances.
module tb_fifo_multi_lane;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fifo_multi_lane_if ifa ();
  fifo_multi_lane_if ifb ();
  fifo_multi_lane_if ifc ();
  fifo_multi_lane                 dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  fifo_multi_lane #(.PARTIAL(0))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  fifo_multi_lane #(.FLUSH_EN(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  typedef struct {
    int sel; int push; int pop; bit fl; int wbase;
    int epa; int eqa; int erbase; int ecnt;
  } vec_t;
  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(int sel, int push, int pop, bit fl, int wb,
                              int epa, int eqa, int erb, int ecnt);
    vq.push_back('{sel, push, pop, fl, wb, epa, eqa, erb, ecnt});
  endfunction
  task automatic drive(int sel, int push, int pop, bit fl, int wb);
    logic [7:0][31:0] w;
    for (int i = 0; i < 8; i++) w[i] = 32'(wb + i);
    ifa.push_cnt = (sel == 0) ? 4'(push) : '0;
    ifa.pop_cnt  = (sel == 0) ? 4'(pop) : '0;
    ifa.flush    = (sel == 0) ? fl : 1'b0;
    ifa.wdata    = w;
    ifb.push_cnt = (sel == 1) ? 4'(push) : '0;
    ifb.pop_cnt  = (sel == 1) ? 4'(pop) : '0;
    ifb.flush    = (sel == 1) ? fl : 1'b0;
    ifb.wdata    = w;
    ifc.push_cnt = (sel == 2) ? 4'(push) : '0;
    ifc.pop_cnt  = (sel == 2) ? 4'(pop) : '0;
    ifc.flush    = (sel == 2) ? fl : 1'b0;
    ifc.wdata    = w;
  endtask
  task automatic sample(int sel, output logic [3:0] pa, output logic [3:0] qa,
                        output logic [255:0] rd, output logic [5:0] cnt,
                        output logic [5:0] fr, output logic [2:0] fg);
    if (sel == 0) begin
      pa = ifa.push_acc; qa = ifa.pop_acc; rd = ifa.rdata; cnt = ifa.count; fr = ifa.free;
      fg = {ifa.full, ifa.empty, ifa.afull};
    end else if (sel == 1) begin
      pa = ifb.push_acc; qa = ifb.pop_acc; rd = ifb.rdata; cnt = ifb.count; fr = ifb.free;
      fg = {ifb.full, ifb.empty, ifb.afull};
    end else begin
      pa = ifc.push_acc; qa = ifc.pop_acc; rd = ifc.rdata; cnt = ifc.count; fr = ifc.free;
      fg = {ifc.full, ifc.empty, ifc.afull};
    end
  endtask
  task automatic apply(int k, vec_t v);
    logic [3:0] pa, qa;
    logic [255:0] rd;
    logic [5:0] cnt, fr;
    logic [2:0] fg;
    logic [7:0][31:0] e;
    drive(v.sel, v.push, v.pop, v.fl, v.wbase);
    #1;
    sample(v.sel, pa, qa, rd, cnt, fr, fg);
    for (int i = 0; i < 8; i++) e[i] = (i < v.eqa) ? 32'(v.erbase + i) : 32'd0;
    chk($sformatf("v%0d push_acc", k), 256'(pa), 256'(v.epa));
    chk($sformatf("v%0d pop_acc", k), 256'(qa), 256'(v.eqa));
    chk($sformatf("v%0d rdata", k), rd, e);
    @(posedge clk);
    #1;
    sample(v.sel, pa, qa, rd, cnt, fr, fg);
    chk($sformatf("v%0d count", k), 256'(cnt), 256'(v.ecnt));
    chk($sformatf("v%0d free", k), 256'(fr), 256'(32 - v.ecnt));
    chk($sformatf("v%0d full/empty/afull", k), 256'(fg),
        256'({v.ecnt == 32, v.ecnt == 0, (32 - v.ecnt) < 8}));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [3:0] pa, qa;
    logic [255:0] rd;
    logic [5:0] cnt, fr;
    logic [2:0] fg;
    // default instance: fill, overfill, drain by threes
    add(0, 8, 0, 0, 0,   8, 0, 0, 8);
    add(0, 8, 0, 0, 8,   8, 0, 0, 16);
    add(0, 8, 0, 0, 16,  8, 0, 0, 24);
    add(0, 8, 0, 0, 24,  8, 0, 0, 32);
    add(0, 8, 0, 0, 100, 0, 0, 0, 32);
    for (int k = 0; k < 10; k++) add(0, 0, 3, 0, 0, 0, 3, 3 * k, 32 - 3 * (k + 1));
    add(0, 0, 3, 0, 0, 0, 2, 30, 0);
    // requests above LANES clamp to LANES
    add(0, 15, 0, 0, 900, 8, 0, 0, 8);
    add(0, 0, 15, 0, 0,   0, 8, 900, 0);
    // simultaneous push/pop, and push into empty is not visible same cycle
    add(0, 4, 0, 0, 200, 4, 0, 0, 4);
    add(0, 8, 6, 0, 300, 8, 4, 200, 8);
    add(0, 0, 8, 0, 0,   0, 8, 300, 0);
    add(0, 8, 8, 0, 400, 8, 0, 0, 8);
    add(0, 0, 8, 0, 0,   0, 8, 400, 0);
    // pointers now at 28: burst wraps 28..3
    add(0, 8, 0, 0, 600, 8, 0, 0, 8);
    add(0, 0, 8, 0, 0,   0, 8, 600, 0);
    // partial grant near full, and full with pop still refuses push
    add(0, 8, 0, 0, 1000, 8, 0, 0, 8);
    add(0, 8, 0, 0, 1008, 8, 0, 0, 16);
    add(0, 8, 0, 0, 1016, 8, 0, 0, 24);
    add(0, 6, 0, 0, 1024, 6, 0, 0, 30);
    add(0, 8, 0, 0, 1030, 2, 0, 0, 32);
    add(0, 8, 8, 0, 1032, 0, 8, 1000, 24);
    add(0, 0, 8, 0, 0, 0, 8, 1008, 16);
    add(0, 0, 8, 0, 0, 0, 8, 1016, 8);
    add(0, 0, 8, 0, 0, 0, 8, 1024, 0);
    // flush beats push and pop
    add(0, 8, 0, 0, 700, 8, 0, 0, 8);
    add(0, 8, 0, 0, 708, 8, 0, 0, 16);
    add(0, 4, 0, 0, 716, 4, 0, 0, 20);
    add(0, 8, 8, 1, 720, 0, 0, 0, 0);
    add(0, 2, 0, 0, 800, 2, 0, 0, 2);
    add(0, 0, 2, 0, 0,   0, 2, 800, 0);
    // all-or-nothing instance
    add(1, 8, 0, 0, 3000, 8, 0, 0, 8);
    add(1, 8, 0, 0, 3008, 8, 0, 0, 16);
    add(1, 8, 0, 0, 3016, 8, 0, 0, 24);
    add(1, 3, 0, 0, 3024, 3, 0, 0, 27);
    add(1, 8, 0, 0, 3027, 0, 0, 0, 27);
    add(1, 5, 0, 0, 3027, 5, 0, 0, 32);
    add(1, 0, 8, 0, 0, 0, 8, 3000, 24);
    add(1, 0, 8, 0, 0, 0, 8, 3008, 16);
    add(1, 0, 8, 0, 0, 0, 8, 3016, 8);
    add(1, 0, 3, 0, 0, 0, 3, 3024, 5);
    add(1, 0, 8, 0, 0, 0, 0, 0, 5);
    add(1, 0, 5, 0, 0, 0, 5, 3027, 0);
    // flush ignored when disabled
    add(2, 8, 0, 0, 2000, 8, 0, 0, 8);
    add(2, 8, 0, 0, 2008, 8, 0, 0, 16);
    add(2, 4, 0, 0, 2016, 4, 0, 0, 20);
    add(2, 8, 8, 1, 2020, 8, 8, 2000, 20);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    sample(0, pa, qa, rd, cnt, fr, fg);
    chk("reset count", 256'(cnt), 256'(0));
    chk("reset free", 256'(fr), 256'(32));
    chk("reset full/empty/afull", 256'(fg), 256'(3'b010));
    chk("reset push_acc", 256'(pa), 256'(0));
    chk("reset pop_acc", 256'(qa), 256'(0));
    chk("reset rdata", rd, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vq[k]) begin
      @(negedge clk);
      apply(k, vq[k]);
    end
    // asynchronous reset mid-burst
    @(negedge clk);
    drive(0, 8, 0, 0, 0);
    @(posedge clk);
    #1;
    sample(0, pa, qa, rd, cnt, fr, fg);
    chk("pre-reset count", 256'(cnt), 256'(8));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sample(0, pa, qa, rd, cnt, fr, fg);
    chk("async reset count", 256'(cnt), 256'(0));
    chk("async reset flags", 256'(fg), 256'(3'b010));
    @(posedge clk);
    #1;
    sample(0, pa, qa, rd, cnt, fr, fg);
    chk("held reset count", 256'(cnt), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    sample(0, pa, qa, rd, cnt, fr, fg);
    chk("post-reset count", 256'(cnt), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
